// File: rtl/evt_counter_pkg.sv
// Shared types and the increment helper for the event counter bank.
// The response struct is width-parameterised through a macro so each instance sizes it exactly.
`ifndef EVT_RD_RSP_T
`define EVT_RD_RSP_T(W) struct packed { logic [(W)-1:0] data; logic ovf; logic err; }
`endif

package evt_counter_pkg;

   localparam int unsigned CNT_MAX_W = 32;

   typedef enum logic [0:0] {
      RD_IDLE = 1'b0,
      RD_RESP = 1'b1
   } rd_state_e;

   // Counters up to CNT_MAX_W bits are zero-extended into this helper; callers truncate the result.
   function automatic logic [CNT_MAX_W-1:0] sat_or_wrap_inc(
      input  logic [CNT_MAX_W-1:0] count,
      input  int unsigned          width,
      input  logic                 sat,
      output logic                 ovf_evt
   );
      logic [CNT_MAX_W-1:0] max_v;
      logic [CNT_MAX_W-1:0] nxt_v;
      if (width >= CNT_MAX_W) begin
         max_v = '1;
      end else begin
         max_v = (CNT_MAX_W'(1) << width) - CNT_MAX_W'(1);
      end
      ovf_evt = (count == max_v);
      if (!ovf_evt) begin
         nxt_v = count + CNT_MAX_W'(1);
      end else if (sat) begin
         nxt_v = count;
      end else begin
         nxt_v = '0;
      end
      return nxt_v;
   endfunction

endpackage

// File: rtl/evt_counter_ch.sv
// One event counter channel: clear, read-clear and increment with sticky overflow.
module evt_counter_ch
   import evt_counter_pkg::*;
#(
   parameter int unsigned WIDTH    = 8,
   parameter int unsigned SATURATE = 0,
   parameter int unsigned THRESH   = 42
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   input  logic             clr,
   input  logic             rdclr,
   output logic [WIDTH-1:0] count,
   output logic             ovf,
   output logic             thresh_hit
);

   logic [WIDTH-1:0] count_d, count_q;
   logic             ovf_d, ovf_q;
   logic [WIDTH-1:0] count_inc_s;
   logic             ovf_evt_s;

   // Next count/overflow with clear > read-clear > increment priority.
   always_comb begin
      ovf_evt_s   = 1'b0;
      count_inc_s = WIDTH'(sat_or_wrap_inc(CNT_MAX_W'(count_q), WIDTH, (SATURATE != 0), ovf_evt_s));
      count_d     = count_q;
      ovf_d       = ovf_q;
      if (clr) begin
         count_d = '0;
         ovf_d   = 1'b0;
      end else if (rdclr) begin
         count_d = {{(WIDTH-1){1'b0}}, inc};
         ovf_d   = 1'b0;
      end else if (inc) begin
         count_d = count_inc_s;
         ovf_d   = ovf_q | ovf_evt_s;
      end else begin
         count_d = count_q;
         ovf_d   = ovf_q;
      end
   end

   // Channel state registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
         ovf_q   <= 1'b0;
      end else begin
         count_q <= count_d;
         ovf_q   <= ovf_d;
      end
   end

   assign count      = count_q;
   assign ovf        = ovf_q;
   assign thresh_hit = (count_q >= WIDTH'(THRESH));

endmodule

// File: rtl/evt_counter_bank.sv
// Bank of NUM_CH event counters with a single valid/ready snapshot read port.
module evt_counter_bank
   import evt_counter_pkg::*;
#(
   parameter int unsigned NUM_CH   = 4,
   parameter int unsigned WIDTH    = 8,
   parameter int unsigned SATURATE = 0,
   parameter int unsigned THRESH   = 42,
   localparam int unsigned CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NUM_CH-1:0] inc_i,
   input  logic [NUM_CH-1:0] clr_i,
   input  logic              rd_req_valid_i,
   output logic              rd_req_ready_o,
   input  logic [CH_W-1:0]   rd_req_ch_i,
   input  logic              rd_req_clr_i,
   output logic              rd_rsp_valid_o,
   input  logic              rd_rsp_ready_i,
   output logic [WIDTH-1:0]  rd_rsp_data_o,
   output logic              rd_rsp_ovf_o,
   output logic              rd_rsp_err_o,
   output logic [NUM_CH-1:0] thresh_hit_o
);

   typedef `EVT_RD_RSP_T(WIDTH) rd_rsp_t;

   rd_state_e        state_d, state_q;
   rd_rsp_t          rsp_d, rsp_q;
   rd_rsp_t          sel_s;
   logic             req_fire_s;
   logic             ch_ok_s;
   logic [WIDTH-1:0] ch_count_s [NUM_CH];
   logic [NUM_CH-1:0] ch_ovf_s;
   logic [NUM_CH-1:0] rdclr_s;

   assign req_fire_s = (state_q == RD_IDLE) & rd_req_valid_i;
   assign ch_ok_s    = ({1'b0, rd_req_ch_i} < (CH_W+1)'(NUM_CH));

   for (genvar c = 0; c < NUM_CH; c++) begin : gen_ch
      assign rdclr_s[c] = req_fire_s & rd_req_clr_i & (rd_req_ch_i == CH_W'(c));

      evt_counter_ch #(
         .WIDTH   (WIDTH),
         .SATURATE(SATURATE),
         .THRESH  (THRESH)
      ) u_ch (
         .clk       (clk),
         .rst       (rst),
         .inc       (inc_i[c]),
         .clr       (clr_i[c]),
         .rdclr     (rdclr_s[c]),
         .count     (ch_count_s[c]),
         .ovf       (ch_ovf_s[c]),
         .thresh_hit(thresh_hit_o[c])
      );
   end

   // One-hot AND-OR channel mux; out-of-range channels leave data/ovf at zero.
   always_comb begin
      sel_s     = '0;
      sel_s.err = ~ch_ok_s;
      for (int c = 0; c < NUM_CH; c++) begin
         sel_s.data = sel_s.data | ({WIDTH{rd_req_ch_i == CH_W'(c)}} & ch_count_s[c]);
         sel_s.ovf  = sel_s.ovf  | ((rd_req_ch_i == CH_W'(c)) & ch_ovf_s[c]);
      end
   end

   // Read FSM next state and response capture.
   always_comb begin
      state_d = state_q;
      rsp_d   = rsp_q;
      case (state_q)
         RD_IDLE: begin
            if (rd_req_valid_i) begin
               state_d = RD_RESP;
               rsp_d   = sel_s;
            end else begin
               state_d = RD_IDLE;
            end
         end
         RD_RESP: begin
            if (rd_rsp_ready_i) begin
               state_d = RD_IDLE;
            end else begin
               state_d = RD_RESP;
            end
         end
         default: state_d = RD_IDLE;
      endcase
   end

   // Read FSM state and response registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= RD_IDLE;
         rsp_q   <= '0;
      end else begin
         state_q <= state_d;
         rsp_q   <= rsp_d;
      end
   end

   assign rd_req_ready_o = (state_q == RD_IDLE);
   assign rd_rsp_valid_o = (state_q == RD_RESP);
   assign rd_rsp_data_o  = rsp_q.data;
   assign rd_rsp_ovf_o   = rsp_q.ovf;
   assign rd_rsp_err_o   = rsp_q.err;

endmodule
